ascii_pair_parser: RTL

Stream source for the two-list solver datapath. Accepts puzzle input as a raw ASCII byte stream, one byte per cycle. Each line has the form `<decimal> <spaces> <decimal> <newline>`. For each line the block emits one pair on `data_stream1`/`data_stream2` with a one-cycle `valid`, then a one-cycle `done` at end of input. Its outputs connect directly to the solver's `data_stream1`, `data_stream2`, `valid` and `done` inputs.

---
 rtl/aoc_pkg.sv | 27 ++
 rtl/decimal_accumulator.sv | 44 ++++
 rtl/ascii_pair_parser.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/aoc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : aoc_pkg
//  Description : Shared definitions for the two-list solver stream front end.
//                ASCII character constants and the line-parser state type.
//  Revision    : 1.0 - initial release
// ============================================================================
package aoc_pkg;

  localparam logic [7:0] ASCII_0   = 8'h30;
  localparam logic [7:0] ASCII_9   = 8'h39;
  localparam logic [7:0] ASCII_SP  = 8'h20;
  localparam logic [7:0] ASCII_TAB = 8'h09;
  localparam logic [7:0] ASCII_LF  = 8'h0A;
  localparam logic [7:0] ASCII_CR  = 8'h0D;

  typedef enum logic [2:0] {
    LINE_START = 3'd0,
    NUM1       = 3'd1,
    GAP        = 3'd2,
    NUM2       = 3'd3,
    FINISHED   = 3'd4,
    ERR        = 3'd5
  } parse_state_t;

endpackage
`default_nettype wire

// File: rtl/decimal_accumulator.sv
`default_nettype none
// ============================================================================
//  Module      : decimal_accumulator
//  Description : Combinational decimal digit accumulate: result = acc*10 + d,
//                or result = d when load is set (first digit of a number).
//                The product is formed WIDTH+4 bits wide; any set bit above
//                WIDTH-1 raises ovf.
//  Ports       : acc    [WIDTH-1:0] in  running value
//                d      [3:0]       in  digit value 0..9
//                load               in  start a new number with d
//                result [WIDTH-1:0] out low WIDTH bits of the accumulate
//                ovf                out accumulate does not fit in WIDTH bits
//  Revision    : 1.0 - initial release
// ============================================================================
module decimal_accumulator
  import aoc_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] acc,
  input  logic [3:0]       d,
  input  logic             load,
  output logic [WIDTH-1:0] result,
  output logic             ovf
);

  localparam logic [WIDTH+3:0] TEN = {{WIDTH{1'b0}}, 4'd10};

  logic [WIDTH+3:0] wide;

  always_comb begin
    if (load) begin
      wide = {{WIDTH{1'b0}}, d};
    end else begin
      // 10*(2^WIDTH-1)+9 < 2^(WIDTH+4), so the wide result never wraps.
      wide = ({4'b0000, acc} * TEN) + {{WIDTH{1'b0}}, d};
    end
  end

  assign result = wide[WIDTH-1:0];
  assign ovf    = |wide[WIDTH+3:WIDTH];

endmodule
`default_nettype wire

// File: rtl/ascii_pair_parser.sv
`default_nettype none
// ============================================================================
//  Module      : ascii_pair_parser
//  Description : Parses an ASCII byte stream of lines "<dec> <ws> <dec> LF"
//                into number pairs for the two-list solver. One valid pulse
//                per pair, one done pulse after the final pair, sticky error
//                on malformed input or numeric overflow.
//  Ports       : clk                          clock, rising edge
//                rst_n                        synchronous active-low reset
//                byte_in [7:0]                ASCII byte
//                byte_valid                   byte_in consumed this cycle
//                byte_last                    final byte (with byte_valid)
//                data_stream1/2 [WIDTH-1:0]   most recent pair, held
//                valid                        pair pulse
//                done                         end-of-input pulse
//                error                        sticky error flag
//  Revision    : 1.0 - initial release
// ============================================================================
module ascii_pair_parser
  import aoc_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       byte_in,
  input  logic             byte_valid,
  input  logic             byte_last,
  output logic [WIDTH-1:0] data_stream1,
  output logic [WIDTH-1:0] data_stream2,
  output logic             valid,
  output logic             done,
  output logic             error
);

  parse_state_t     state, state_nxt;
  logic [WIDTH-1:0] acc1, acc2, acc1_nxt, acc2_nxt;
  logic             trail, trail_nxt;
  logic             done_pending, done_pending_nxt;
  logic             emit, done_now;

  logic             is_digit, is_sp, is_lf, is_cr;
  logic [WIDTH-1:0] mac_in, mac_out;
  logic             mac_load, mac_ovf;

  assign is_digit = (byte_in >= ASCII_0) && (byte_in <= ASCII_9);
  assign is_sp    = (byte_in == ASCII_SP) || (byte_in == ASCII_TAB);
  assign is_lf    = (byte_in == ASCII_LF);
  assign is_cr    = (byte_in == ASCII_CR);

  // One shared accumulator: the second number is being built only in NUM2,
  // and the first digit of either number arrives in LINE_START or GAP.
  assign mac_in   = (state == NUM2) ? acc2 : acc1;
  assign mac_load = (state == LINE_START) || (state == GAP);

  decimal_accumulator #(
    .WIDTH (WIDTH)
  ) u_mac (
    .acc    (mac_in),
    .d      (byte_in[3:0]),
    .load   (mac_load),
    .result (mac_out),
    .ovf    (mac_ovf)
  );

  always_comb begin
    state_nxt        = state;
    acc1_nxt         = acc1;
    acc2_nxt         = acc2;
    trail_nxt        = trail;
    done_pending_nxt = 1'b0;
    emit             = 1'b0;
    done_now         = 1'b0;

    if (byte_valid && !is_cr) begin
      case (state)
        LINE_START: begin
          if (is_digit) begin
            acc1_nxt  = mac_out;
            state_nxt = NUM1;
          end else if (is_lf) begin
            trail_nxt = 1'b0;
          end else if (!(is_sp && trail)) begin
            // Whitespace is tolerated here only as trailing space after a
            // pair that was closed by a space.
            state_nxt = ERR;
          end
        end
        NUM1: begin
          if (is_digit) begin
            if (mac_ovf) state_nxt = ERR;
            else         acc1_nxt  = mac_out;
          end else if (is_sp) begin
            state_nxt = GAP;
          end else begin
            state_nxt = ERR;
          end
        end
        GAP: begin
          if (is_digit) begin
            acc2_nxt  = mac_out;
            state_nxt = NUM2;
          end else if (!is_sp) begin
            state_nxt = ERR;
          end
        end
        NUM2: begin
          if (is_digit) begin
            if (mac_ovf) state_nxt = ERR;
            else         acc2_nxt  = mac_out;
          end else if (is_lf) begin
            emit      = 1'b1;
            trail_nxt = 1'b0;
            state_nxt = LINE_START;
          end else if (is_sp) begin
            emit      = 1'b1;
            trail_nxt = 1'b1;
            state_nxt = LINE_START;
          end else begin
            state_nxt = ERR;
          end
        end
        default: ;
      endcase
    end

    // End of input: the final byte has already been applied above.
    if (byte_valid && byte_last && (state != FINISHED) && (state != ERR) &&
        (state_nxt != ERR)) begin
      if (emit || (state_nxt == NUM2)) begin
        // A number still open in NUM2 is closed by end of input.
        emit             = 1'b1;
        done_pending_nxt = 1'b1;
        state_nxt        = FINISHED;
      end else if (state_nxt == LINE_START) begin
        done_now  = 1'b1;
        state_nxt = FINISHED;
      end else begin
        state_nxt = ERR;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= LINE_START;
      acc1         <= '0;
      acc2         <= '0;
      trail        <= 1'b0;
      done_pending <= 1'b0;
      data_stream1 <= '0;
      data_stream2 <= '0;
      valid        <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
    end else begin
      state        <= state_nxt;
      acc1         <= acc1_nxt;
      acc2         <= acc2_nxt;
      trail        <= trail_nxt;
      done_pending <= done_pending_nxt;
      valid        <= emit;
      // done follows the final valid by one cycle, never coinciding with it.
      done         <= done_now | done_pending;
      if (emit) begin
        data_stream1 <= acc1_nxt;
        data_stream2 <= acc2_nxt;
      end
      if (state_nxt == ERR) begin
        error <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire
